// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator keypad sequencer.
package calc_pkg;

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    CALC    = 2'd2,
    SHOW    = 2'd3
  } calc_state_t;

  localparam logic [3:0] KEY_PLUS  = 4'hA;
  localparam logic [3:0] KEY_MINUS = 4'hB;
  localparam logic [3:0] KEY_EQ    = 4'hE;
  localparam logic [3:0] KEY_CLR   = 4'hF;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;

  function automatic logic is_digit(input logic [3:0] key);
    return key <= 4'd9;
  endfunction

  function automatic logic [1:0] op_of(input logic [3:0] key);
    return (key == KEY_MINUS) ? OP_SUB : OP_ADD;
  endfunction

endpackage

// File: rtl/calc_sequencer.sv
// Keypad-driven control FSM for the calculator datapath: issues the A/B/C load
// strobes, buffer clears, LCD operator code and result-chaining select.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int CALC_CYCLES = 4
) (
  input  logic       clk,
  input  logic       regreset,
  input  logic       key_valid,
  input  logic [3:0] key_value,
  output logic       load_a,
  output logic       load_b,
  output logic       load_c,
  output logic       reg_clear,
  output logic       entry_clear,
  output logic       a_sel_result,
  output logic [1:0] operation,
  output logic       busy,
  output logic       err
);

  localparam logic [7:0] CALC_INIT = 8'(CALC_CYCLES);

  calc_state_t state_q, state_d;
  logic [7:0]  count_q, count_d;
  logic        key_prev_q;

  logic load_a_d, load_b_d, load_c_d, reg_clear_d, entry_clear_d;
  logic a_sel_d, busy_d, err_d;
  logic [1:0] op_d;

  logic key_event, ev_op, ev_eq, ev_clr, ev_bad, ev_digit;

  assign key_event = key_valid & ~key_prev_q;
  assign ev_op     = key_event & ((key_value == KEY_PLUS) | (key_value == KEY_MINUS));
  assign ev_eq     = key_event & (key_value == KEY_EQ);
  assign ev_clr    = key_event & (key_value == KEY_CLR);
  assign ev_bad    = key_event & ((key_value == 4'hC) | (key_value == 4'hD));
  assign ev_digit  = key_event & is_digit(key_value);

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    load_a_d      = 1'b0;
    load_b_d      = 1'b0;
    load_c_d      = 1'b0;
    reg_clear_d   = 1'b0;
    entry_clear_d = 1'b0;
    a_sel_d       = 1'b0;
    op_d          = operation;
    err_d         = err;

    if (ev_clr) begin
      reg_clear_d   = 1'b1;
      entry_clear_d = 1'b1;
      op_d          = OP_NONE;
      err_d         = 1'b0;
      count_d       = 8'd0;
      state_d       = ENTER_A;
    end else begin
      case (state_q)
        ENTER_A: begin
          if (ev_op) begin
            load_a_d      = 1'b1;
            entry_clear_d = 1'b1;
            op_d          = op_of(key_value);
            err_d         = 1'b0;
            state_d       = ENTER_B;
          end else if (ev_eq || ev_bad) begin
            err_d = 1'b1;
          end
        end
        ENTER_B: begin
          if (ev_eq) begin
            load_b_d      = 1'b1;
            entry_clear_d = 1'b1;
            count_d       = CALC_INIT;
            err_d         = 1'b0;
            state_d       = CALC;
          end else if (ev_op || ev_bad) begin
            err_d = 1'b1;
          end
        end
        CALC: begin
          // Fire load_c on the cycle the decremented count reaches zero.
          count_d = count_q - 8'd1;
          if (count_q <= 8'd1) begin
            count_d  = 8'd0;
            load_c_d = 1'b1;
            state_d  = SHOW;
          end
        end
        SHOW: begin
          if (ev_op) begin
            load_a_d      = 1'b1;
            a_sel_d       = 1'b1;
            entry_clear_d = 1'b1;
            op_d          = op_of(key_value);
            err_d         = 1'b0;
            state_d       = ENTER_B;
          end else if (ev_digit) begin
            reg_clear_d = 1'b1;
            op_d        = OP_NONE;
            state_d     = ENTER_A;
          end else if (ev_eq || ev_bad) begin
            err_d = 1'b1;
          end
        end
        default: state_d = ENTER_A;
      endcase
    end

    busy_d = (state_d == CALC);
  end

  // Edge register resets to 1 so a key held through reset is not an event.
  always_ff @(posedge clk) begin
    if (regreset) begin
      state_q      <= ENTER_A;
      count_q      <= 8'd0;
      key_prev_q   <= 1'b1;
      load_a       <= 1'b0;
      load_b       <= 1'b0;
      load_c       <= 1'b0;
      reg_clear    <= 1'b0;
      entry_clear  <= 1'b0;
      a_sel_result <= 1'b0;
      operation    <= OP_NONE;
      busy         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      key_prev_q   <= key_valid;
      load_a       <= load_a_d;
      load_b       <= load_b_d;
      load_c       <= load_c_d;
      reg_clear    <= reg_clear_d;
      entry_clear  <= entry_clear_d;
      a_sel_result <= a_sel_d;
      operation    <= op_d;
      busy         <= busy_d;
      err          <= err_d;
    end
  end

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Control FSM for the calculator datapath. It replaces the three manual load buttons on the operand/result registers. It takes key events from the keypad input module and produces single-cycle load strobes for registers A, B and C. It also drives the digit-buffer clear, the operation code shown on the LCD, and a result-chaining select, so a full `A op B =` sequence runs from the keypad alone.

## Interface
Parameters:
- `CALC_CYCLES`, default 4: `clk` cycles allowed for the combinational adder to settle after B loads, before C loads (range 1..255).

Ports:
- `clk`  in  1  50 MHz system clock.
- `regreset`  in  1  reset. One clock; reset is synchronous and active-high.
- `key_valid`  in  1  key-event level from keypad scanner; held any number of cycles.
- `key_value`  in  4  key code, valid while `key_valid`=1.
- `load_a`  out  1  one-cycle strobe to register A.
- `load_b`  out  1  one-cycle strobe to register B.
- `load_c`  out  1  one-cycle strobe to register C.
- `reg_clear`  out  1  one-cycle clear to registers A/B/C.
- `entry_clear`  out  1  one-cycle clear to keypad digit buffer.
- `a_sel_result`  out  1  1 = A-register D input muxed from result, 0 = from keypad buffer.
- `operation`  out  2  LCD operator: 00 none, 01 plus, 10 minus.
- `busy`  out  1  high in CALC.
- `err`  out  1  sticky illegal-key flag.

## Operation
- Key decode: digits 0x0–0x9 are pass-through with no FSM action. 0xA = plus, 0xB = minus, 0xE = equals, 0xF = clear. 0xC and 0xD are illegal.
- Key event = rising edge of `key_valid` (registered previous level). Holding a key produces one event.
- States: ENTER_A, ENTER_B, CALC, SHOW.
- ENTER_A, on plus/minus:
  - pulse `load_a` and `entry_clear`
  - `operation` ← 01/10
  - → ENTER_B.
- ENTER_B, on equals:
  - pulse `load_b` and `entry_clear`
  - load settle counter with `CALC_CYCLES`
  - → CALC.
- CALC:
  - counter decrements each cycle; all key events ignored.
  - at count 0, pulse `load_c` → SHOW.
- SHOW, on plus/minus (chaining):
  - `a_sel_result`=1 in the same cycle as the `load_a` pulse.
  - `operation` ← new op; pulse `entry_clear`.
  - → ENTER_B. `a_sel_result` returns to 0 the next cycle.
- SHOW, on digit:
  - pulse `reg_clear`
  - `operation` ← 00
  - → ENTER_A. The digit remains in the keypad buffer.
- Clear, in any state including CALC:
  - pulse `reg_clear` and `entry_clear`
  - `operation` ← 00, `err` ← 0
  - → ENTER_A.
- Illegal events set `err` and leave state unchanged:
  - 0xC or 0xD in any state except CALC
  - equals in ENTER_A
  - plus/minus in ENTER_B
  - equals in SHOW
- `err` clears on the next legal non-digit event or on clear.
- At most one of `load_a`/`load_b`/`load_c`/`reg_clear` is high in any cycle.

## Timing
- All outputs are registered and glitch-free, because the strobes clock the existing registers.
- Reset (synchronous, `regreset`=1 at a rising edge) sets:
  - state ENTER_A, counter 0
  - all strobes 0, `a_sel_result` 0, `operation` 00, `busy` 0, `err` 0
  - edge-detect register 1, so a key held through reset produces no event.
- Event latency: `key_valid` rises in cycle n and is sampled at edge n. The strobe is high for cycle n+1 only.
- Load-C latency: `load_b` high in cycle n+1 → `busy` high from n+1 → `load_c` high in cycle n+1+`CALC_CYCLES` → `busy` low in that same cycle.
- Reset asserted during CALC aborts with no `load_c`.
- Clear during CALC aborts with no `load_c`; `reg_clear` is high the next cycle.

## Structure
- Package `calc_pkg`:
  - state enum `calc_state_t`
  - key-code constants `KEY_PLUS`, `KEY_MINUS`, `KEY_EQ`, `KEY_CLR`
  - op codes `OP_NONE`, `OP_ADD`, `OP_SUB`.
- Single module; no sub-module. The edge detector stays inline.
- The top level adds a 2:1 mux on register A's D input, driven by `a_sel_result`.

## Test plan
- Reset, then keys 5, plus, 3, equals with `CALC_CYCLES`=4 → `load_a` at event+1, `operation`=01, `load_b` at event+1, `load_c` exactly 4 cycles after `load_b`; `busy` high for those 4 cycles.
- Hold `key_valid` with 0xA for 10 cycles in ENTER_A → exactly one `load_a`, one `entry_clear`.
- In SHOW, press minus → `load_a` with `a_sel_result`=1 in the same cycle, `operation`=10, state ENTER_B; `a_sel_result`=0 the next cycle.
- Equals in ENTER_A → `err`=1, no strobes; then plus → `err`=0 with `load_a`.
- Clear 2 cycles into CALC → `reg_clear` and `entry_clear` next cycle, no `load_c` ever, `operation`=00, state ENTER_A.
- `regreset` high while `key_valid`=1 with 0xA, then release `regreset` with the key still held → no strobe until the key is released and pressed again.
